// File: rtl/gilbert_elliott_channel.sv
// Two-state Gilbert-Elliott burst-noise channel: LFSR-driven additive noise scaled by
// per-state SNR, Markov GOOD/BAD transitions, bypass mode and burst statistics.
module gilbert_elliott_channel #(
    parameter int                 DATA_W    = 16,
    parameter int                 LFSR_W    = 16,
    parameter logic [LFSR_W-1:0]  LFSR_TAPS = 16'hB400,
    parameter logic [LFSR_W-1:0]  LFSR_SEED = 16'hACE1,
    parameter int                 CNT_W     = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                chan_en,
    input  logic                in_valid,
    input  logic [DATA_W-1:0]   in_data,
    input  logic [7:0]          p_gb,
    input  logic [7:0]          p_bg,
    input  logic [4:0]          snr_good,
    input  logic [4:0]          snr_bad,
    output logic                out_valid,
    output logic [DATA_W-1:0]   out_data,
    output logic                state,
    output logic [4:0]          SNR,
    output logic [LFSR_W-1:0]   rand_num,
    output logic [CNT_W-1:0]    bad_cycles,
    output logic [CNT_W-1:0]    burst_count,
    output logic [CNT_W-1:0]    burst_len
);

    typedef enum logic {GOOD = 1'b0, BAD = 1'b1} state_t;

    localparam logic [LFSR_W-1:0] SEED_EFF = (LFSR_SEED == '0) ? LFSR_W'(1) : LFSR_SEED;
    localparam int SUM_W = DATA_W + 1;
    localparam logic signed [SUM_W-1:0] MAX_V = {2'b00, {(DATA_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] MIN_V = {2'b11, {(DATA_W-1){1'b0}}};

    state_t                    state_q, state_d;
    logic [LFSR_W-1:0]         lfsr_d;
    logic [CNT_W-1:0]          bad_d, bc_d, bl_d;
    logic                      accept;
    logic [7:0]                r_lo;
    logic signed [7:0]         noise8;
    logic [2:0]                shift;
    logic signed [SUM_W-1:0]   in_ext, noise_ext, noise_sh, sum;
    logic [DATA_W-1:0]         sat_data;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign state  = state_q;
    assign SNR    = (state_q == BAD) ? snr_bad : snr_good;
    assign accept = in_valid && chan_en;
    assign r_lo   = rand_num[7:0];
    assign noise8 = rand_num[15:8];
    // Each 4 dB-ish step of SNR below 31 doubles the noise amplitude.
    assign shift  = 3'((5'd31 - SNR) >> 2);

    always_comb begin
        in_ext    = {{(SUM_W-DATA_W){in_data[DATA_W-1]}}, in_data};
        noise_ext = {{(SUM_W-8){noise8[7]}}, noise8};
        noise_sh  = noise_ext <<< shift;
        sum       = in_ext + noise_sh;
        sat_data  = sum[DATA_W-1:0];
        if (sum > MAX_V) begin
            sat_data = MAX_V[DATA_W-1:0];
        end else if (sum < MIN_V) begin
            sat_data = MIN_V[DATA_W-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        lfsr_d  = rand_num;
        bad_d   = bad_cycles;
        bc_d    = burst_count;
        bl_d    = burst_len;
        if (accept) begin
            lfsr_d = rand_num[0] ? ((rand_num >> 1) ^ LFSR_TAPS) : (rand_num >> 1);
            if (state_q == BAD) begin
                bad_d = sat_inc(bad_cycles);
                if (r_lo < p_bg) begin
                    state_d = GOOD;
                end else begin
                    bl_d = sat_inc(burst_len);
                end
            end else if (r_lo < p_gb) begin
                state_d = BAD;
                bc_d    = sat_inc(burst_count);
                bl_d    = CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= GOOD;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rand_num    <= SEED_EFF;
            out_valid   <= 1'b0;
            out_data    <= '0;
            bad_cycles  <= '0;
            burst_count <= '0;
            burst_len   <= '0;
        end else begin
            out_valid   <= in_valid;
            rand_num    <= lfsr_d;
            bad_cycles  <= bad_d;
            burst_count <= bc_d;
            burst_len   <= bl_d;
            if (in_valid) begin
                out_data <= chan_en ? sat_data : in_data;
            end
        end
    end

endmodule

// File: tb/tb_gilbert_elliott_channel.sv
// Scoreboard bench for gilbert_elliott_channel; a second instance with 4-bit counters
// shares all inputs to exercise counter saturation.
module tb_gilbert_elliott_channel;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        chan_en = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic [7:0]  p_gb = '0, p_bg = '0;
    logic [4:0]  snr_good = 5'd20, snr_bad = 5'd4;

    logic        out_valid, state;
    logic [15:0] out_data, rand_num, bad_cycles, burst_count, burst_len;
    logic [4:0]  snr_out;

    logic        out_valid4, state4;
    logic [15:0] out_data4, rand_num4;
    logic [4:0]  snr_out4;
    logic [3:0]  bad_cycles4, burst_count4, burst_len4;

    gilbert_elliott_channel dut (
        .clk(clk), .reset(reset), .chan_en(chan_en), .in_valid(in_valid), .in_data(in_data),
        .p_gb(p_gb), .p_bg(p_bg), .snr_good(snr_good), .snr_bad(snr_bad),
        .out_valid(out_valid), .out_data(out_data), .state(state), .SNR(snr_out),
        .rand_num(rand_num), .bad_cycles(bad_cycles), .burst_count(burst_count),
        .burst_len(burst_len)
    );

    gilbert_elliott_channel #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .chan_en(chan_en), .in_valid(in_valid), .in_data(in_data),
        .p_gb(p_gb), .p_bg(p_bg), .snr_good(snr_good), .snr_bad(snr_bad),
        .out_valid(out_valid4), .out_data(out_data4), .state(state4), .SNR(snr_out4),
        .rand_num(rand_num4), .bad_cycles(bad_cycles4), .burst_count(burst_count4),
        .burst_len(burst_len4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic        st;
        logic [15:0] rnd, bad, bc, bl;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] m_lfsr, m_bad, m_bc, m_bl;
    logic        m_state;
    int          n_cmp = 0;
    int          n_bad = 0;

    // Reference channel: advances the model for the sample currently on the inputs.
    function automatic void model_step();
        exp_t e;
        int   snr, sh, n8, sum;
        logic [7:0] r_lo;
        logic nxt;
        if (!chan_en) begin
            e.data = in_data;
        end else begin
            r_lo = m_lfsr[7:0];
            snr  = m_state ? int'(snr_bad) : int'(snr_good);
            sh   = (31 - snr) / 4;
            n8   = int'($signed(m_lfsr[15:8]));
            sum  = int'($signed(in_data)) + n8 * (1 << sh);
            if (sum > 32767)  sum = 32767;
            if (sum < -32768) sum = -32768;
            e.data = 16'(sum);
            nxt = m_state ? (r_lo >= p_bg) : (r_lo < p_gb);
            if (m_state && m_bad != 16'hFFFF) m_bad = m_bad + 1;
            if (!m_state && nxt) begin
                if (m_bc != 16'hFFFF) m_bc = m_bc + 1;
                m_bl = 1;
            end else if (m_state && nxt && m_bl != 16'hFFFF) begin
                m_bl = m_bl + 1;
            end
            m_state = nxt;
            m_lfsr  = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
        end
        e.st = m_state; e.rnd = m_lfsr; e.bad = m_bad; e.bc = m_bc; e.bl = m_bl;
        sb.push_back(e);
    endfunction

    function automatic string fmt_obs();
        return $sformatf("data=%h st=%b rnd=%h bad=%0d bc=%0d bl=%0d vld=%b",
                         out_data, state, rand_num, bad_cycles, burst_count, burst_len, out_valid);
    endfunction

    function automatic string fmt_exp(input exp_t e);
        return $sformatf("data=%h st=%b rnd=%h bad=%0d bc=%0d bl=%0d vld=1",
                         e.data, e.st, e.rnd, e.bad, e.bc, e.bl);
    endfunction

    task automatic drive_sample(input logic [15:0] d);
        in_data  = d;
        in_valid = 1'b1;
        model_step();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        m_lfsr = 16'hACE1; m_state = 1'b0; m_bad = '0; m_bc = '0; m_bl = '0;
        sb.delete();
    endtask

    task automatic test_reset();
        chan_en = 1'b1; snr_good = 5'd20; snr_bad = 5'd4; p_gb = 8'd0; p_bg = 8'd0;
        in_valid = 1'b1; in_data = 16'd1234;
        @(posedge clk);
        apply_reset();
        n_cmp++;
        if ({out_valid, out_data, state, rand_num, bad_cycles, burst_count, burst_len} !==
            {1'b0, 16'h0, 1'b0, 16'hACE1, 16'h0, 16'h0, 16'h0}) begin
            n_bad++;
            $display("FAIL reset_state: got %s, need data=0000 st=0 rnd=ace1 counters=0 vld=0", fmt_obs());
        end
        n_cmp++;
        if (snr_out !== 5'd20) begin
            n_bad++;
            $display("FAIL reset_snr: got %0d, need 20", snr_out);
        end
        n_cmp++;
        if ({bad_cycles4, burst_count4, burst_len4} !== 12'h000) begin
            n_bad++;
            $display("FAIL reset_cnt4: got %h, need 000", {bad_cycles4, burst_count4, burst_len4});
        end
    endtask

    task automatic test_no_burst();
        exp_t e;
        int   diff;
        apply_reset();
        chan_en = 1'b1; p_gb = 8'd0; p_bg = 8'd0; snr_good = 5'd20;
        for (int i = 0; i < 10000; i++) begin
            drive_sample(16'd1000);
            e = sb.pop_front();
            diff = int'($signed(out_data)) - 1000;
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== e.data || state !== 1'b0) begin
                n_bad++;
                $display("FAIL no_burst[%0d]: got %s, need %s", i, fmt_obs(), fmt_exp(e));
            end
            n_cmp++;
            if (diff < -512 || diff > 508) begin
                n_bad++;
                $display("FAIL noise_bound[%0d]: got %0d, need within -512..508", i, diff);
            end
        end
        n_cmp++;
        if ({bad_cycles, burst_count} !== 32'h0) begin
            n_bad++;
            $display("FAIL no_burst_cnt: got bad=%0d bc=%0d, need 0 0", bad_cycles, burst_count);
        end
    endtask

    task automatic test_bit_exact();
        exp_t e;
        int   edges = 0;
        logic prev = 1'b0;
        apply_reset();
        chan_en = 1'b1; p_gb = 8'd64; p_bg = 8'd32; snr_good = 5'd20; snr_bad = 5'd4;
        for (int i = 0; i < 5000; i++) begin
            drive_sample(16'd1000);
            e = sb.pop_front();
            n_cmp++;
            if ({out_valid, out_data, state, rand_num, bad_cycles, burst_count, burst_len} !==
                {1'b1, e.data, e.st, e.rnd, e.bad, e.bc, e.bl}) begin
                n_bad++;
                $display("FAIL bit_exact[%0d]: got %s, need %s", i, fmt_obs(), fmt_exp(e));
            end
            if (!prev && state) edges++;
            prev = state;
        end
        n_cmp++;
        if (burst_count !== 16'(edges) || edges == 0) begin
            n_bad++;
            $display("FAIL burst_edges: got burst_count=%0d, need %0d (nonzero)", burst_count, edges);
        end
    endtask

    task automatic test_saturation();
        exp_t e;
        int   hi = 0, lo = 0;
        apply_reset();
        chan_en = 1'b1; p_gb = 8'd64; p_bg = 8'd32; snr_good = 5'd0; snr_bad = 5'd0;
        for (int i = 0; i < 4000; i++) begin
            drive_sample(i < 2000 ? 16'h7FFF : 16'h8000);
            e = sb.pop_front();
            n_cmp++;
            if ({out_valid, out_data, state, rand_num, bad_cycles, burst_count, burst_len} !==
                {1'b1, e.data, e.st, e.rnd, e.bad, e.bc, e.bl}) begin
                n_bad++;
                $display("FAIL saturate[%0d]: got %s, need %s", i, fmt_obs(), fmt_exp(e));
            end
            if (out_data == 16'h7FFF) hi++;
            if (out_data == 16'h8000) lo++;
        end
        n_cmp++;
        if (hi == 0 || lo == 0) begin
            n_bad++;
            $display("FAIL rails: got hi=%0d lo=%0d hits, need both > 0", hi, lo);
        end
    endtask

    task automatic test_bypass();
        exp_t        e;
        logic [15:0] last = out_data;
        chan_en = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (i % 10 == 9) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
                n_cmp++;
                if ({out_valid, out_data, state, rand_num, bad_cycles, burst_count, burst_len} !==
                    {1'b0, last, m_state, m_lfsr, m_bad, m_bc, m_bl}) begin
                    n_bad++;
                    $display("FAIL bypass_gap[%0d]: got %s, need data=%h vld=0 frozen st=%b rnd=%h",
                             i, fmt_obs(), last, m_state, m_lfsr);
                end
            end else begin
                drive_sample(16'(i));
                e = sb.pop_front();
                last = e.data;
                n_cmp++;
                if ({out_valid, out_data, state, rand_num, bad_cycles, burst_count, burst_len} !==
                    {1'b1, 16'(i), e.st, e.rnd, e.bad, e.bc, e.bl}) begin
                    n_bad++;
                    $display("FAIL bypass[%0d]: got %s, need %s", i, fmt_obs(), fmt_exp(e));
                end
            end
        end
        chan_en = 1'b1;
    endtask

    task automatic test_reset_mid_burst();
        exp_t e;
        chan_en = 1'b1; p_gb = 8'd255; p_bg = 8'd0; snr_good = 5'd20; snr_bad = 5'd4;
        for (int i = 0; i < 8; i++) begin
            drive_sample(16'd500);
            e = sb.pop_front();
            n_cmp++;
            if ({out_valid, out_data, state, rand_num, bad_cycles, burst_count, burst_len} !==
                {1'b1, e.data, e.st, e.rnd, e.bad, e.bc, e.bl}) begin
                n_bad++;
                $display("FAIL pre_reset[%0d]: got %s, need %s", i, fmt_obs(), fmt_exp(e));
            end
        end
        in_valid = 1'b1; in_data = 16'd777;
        apply_reset();
        n_cmp++;
        if ({out_valid, out_data, state, rand_num, bad_cycles, burst_count, burst_len} !==
            {1'b0, 16'h0, 1'b0, 16'hACE1, 16'h0, 16'h0, 16'h0}) begin
            n_bad++;
            $display("FAIL mid_reset: got %s, need data=0000 st=0 rnd=ace1 counters=0 vld=0", fmt_obs());
        end
    endtask

    task automatic test_counter_sat();
        exp_t e;
        apply_reset();
        chan_en = 1'b1; p_gb = 8'd255; p_bg = 8'd0;
        for (int i = 0; i < 40; i++) begin
            drive_sample(16'd0);
            e = sb.pop_front();
            n_cmp++;
            if ({out_valid, out_data, state, rand_num, bad_cycles, burst_count, burst_len} !==
                {1'b1, e.data, e.st, e.rnd, e.bad, e.bc, e.bl}) begin
                n_bad++;
                $display("FAIL cnt_run[%0d]: got %s, need %s", i, fmt_obs(), fmt_exp(e));
            end
        end
        n_cmp++;
        if ({bad_cycles4, burst_len4, burst_count4} !== {4'hF, 4'hF, m_bc[3:0]}) begin
            n_bad++;
            $display("FAIL cnt4_sat: got bad=%0d bl=%0d bc=%0d, need 15 15 %0d",
                     bad_cycles4, burst_len4, burst_count4, m_bc[3:0]);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        m_lfsr = 16'hACE1; m_state = 1'b0; m_bad = '0; m_bc = '0; m_bl = '0;
        test_reset();
        test_no_burst();
        test_bit_exact();
        test_saturation();
        test_bypass();
        test_reset_mid_burst();
        test_counter_sat();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gilbert_elliott_channel.md
Name: gilbert_elliott_channel

Overview:
Parametrised two-state (GOOD/BAD) Gilbert-Elliott burst-noise channel model for the link simulation chain. It sits between the transmitter sample stream and the receiver/demodulator. Per accepted sample it adds LFSR-derived noise whose amplitude follows a per-state SNR, and draws Markov state transitions from run-time-programmable probabilities. Adds valid handshake, bypass mode and burst statistics counters.

Parameters:
DATA_W, 16, sample width (signed two's complement)
LFSR_W, 16, LFSR width, must be >= 16
LFSR_TAPS, 16'hB400, Galois feedback mask (x^16+x^14+x^13+x^11+1)
LFSR_SEED, 16'hACE1, reset value; a zero seed is replaced by 1
CNT_W, 16, statistics counter width

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
chan_en  input  1  1 = channel active, 0 = bypass
in_valid  input  1  sample strobe
in_data  input  DATA_W  signed input sample
p_gb  input  8  GOOD->BAD threshold (probability p_gb/256)
p_bg  input  8  BAD->GOOD threshold (probability p_bg/256)
snr_good  input  5  SNR code in GOOD
snr_bad  input  5  SNR code in BAD
out_valid  output  1  registered in_valid
out_data  output  DATA_W  signed noisy sample
state  output  1  0 = GOOD, 1 = BAD
SNR  output  5  SNR code of current state
rand_num  output  LFSR_W  current LFSR value
bad_cycles  output  CNT_W  accepted samples processed in BAD
burst_count  output  CNT_W  number of GOOD->BAD transitions
burst_len  output  CNT_W  length of current/most recent BAD burst

Behaviour:
- Reset (synchronous, active-high, dominates all other inputs): state=0, LFSR=LFSR_SEED (or 1 if zero), out_valid=0, out_data=0, bad_cycles=0, burst_count=0, burst_len=0. SNR reflects snr_good combinationally.
- SNR = state ? snr_bad : snr_good (combinational from the state register).
- Accepted sample = in_valid=1 at a rising edge. Latency is exactly 1 cycle: out_valid <= in_valid every cycle. out_data updates only on accepted samples and holds otherwise.
- Active mode (chan_en=1), on an accepted sample, all terms are computed from pre-edge register values:
  - r_lo = rand_num[7:0]; noise8 = signed rand_num[15:8].
  - shift = (31 - SNR) >> 2, giving 0..7. noise = sign-extend(noise8) <<< shift.
  - sum = in_data + noise at DATA_W+1 bits, saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. out_data <= sum.
  - Transition: GOOD with r_lo < p_gb -> BAD. BAD with r_lo < p_bg -> GOOD. Otherwise hold. p=0 never transitions.
  - LFSR advances one Galois step: lsb=1 -> (rand>>1)^LFSR_TAPS, else rand>>1.
  - Counters, saturating at all-ones:
    - bad_cycles +1 if pre-edge state=BAD.
    - On GOOD->BAD: burst_count +1 and burst_len <= 1.
    - While staying BAD: burst_len +1.
    - On BAD->GOOD and in GOOD: burst_len holds.
- Bypass (chan_en=0): accepted sample gives out_data <= in_data. LFSR, state and counters are frozen.
- No accepted sample: LFSR, state, counters and out_data hold.
- chan_en changes take effect on the same edge. Threshold and SNR inputs are sampled on every accepted sample, so no latching is needed.
- A mid-stream reset discards any in-flight sample: out_valid=0 on the cycle after reset.

Test Plan:
- Reset then in_valid=1, in_data=1000, p_gb=0, 10000 samples -> state stays 0, bad_cycles=0, burst_count=0. out_data-1000 bounded by ±127<<shift(snr_good).
- Bit-exact check: seed 16'hACE1, p_gb=64, p_bg=32, snr_good=20, snr_bad=4, in_data=1000, 5000 samples -> out_data, state, rand_num and counters match the cycle-accurate reference model every cycle. burst_count equals the GOOD->BAD edges counted on state.
- Saturation: snr_good=0 (shift 7), in_data=32767, then -32768, 2000 samples each -> out_data never wraps and stays within [-32768, 32767]. Both rails are reached at least once.
- Bypass/hold: chan_en=0, in_data ramps 0..99 -> out_data=in_data delayed 1 cycle, rand_num/state/counters unchanged. Gaps with in_valid=0 -> out_valid=0 and everything holds.
- Reset mid-burst: force BAD (p_gb=255, p_bg=0), assert reset for 1 cycle while in_valid=1 -> next cycle state=0, counters=0, rand_num=16'hACE1, out_valid=0.
- Counter saturation: CNT_W=4, p_gb=255, p_bg=0, 40 samples -> bad_cycles and burst_len stick at 15.
